// File: rtl/pe_row_mac.sv
// rtl/pe_row_mac.sv - row-stationary PE: weight scratchpad, sliding ifmap window, serial MAC
module pe_row_mac #(
    parameter int DATA_WIDTH = 16,
    parameter int FLTR_LEN   = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_clr,
    input  logic                      PE_EN,
    input  logic [DATA_WIDTH-1:0]     ifmap_data_M2P,
    input  logic [DATA_WIDTH-1:0]     fltr_data_M2P,
    input  logic [2*DATA_WIDTH-1:0]   psum_data_M2P,
    output logic                      PE_READY,
    output logic                      PE_VALID,
    output logic [2*DATA_WIDTH-1:0]   psum_data_P2M,
    output logic [DATA_WIDTH-1:0]     ifmap_data_P2M,
    output logic [DATA_WIDTH-1:0]     fltr_data_P2M
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(FLTR_LEN + 1);
    localparam int KW = $clog2(FLTR_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           ld_cnt_q, ld_cnt_d;
    logic [KW-1:0]           k_q, k_d;
    logic signed [PW-1:0]    acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0] w_q [FLTR_LEN];
    logic signed [DATA_WIDTH-1:0] w_d [FLTR_LEN];
    logic signed [DATA_WIDTH-1:0] x_q [FLTR_LEN];
    logic signed [DATA_WIDTH-1:0] x_d [FLTR_LEN];
    logic [PW-1:0]           psum_q, psum_d;
    logic [DATA_WIDTH-1:0]   ifmap_q, ifmap_d;
    logic [DATA_WIDTH-1:0]   fltr_q, fltr_d;

    logic                    xfer;
    logic                    compute;
    logic signed [DATA_WIDTH-1:0] w_sel;
    logic signed [DATA_WIDTH-1:0] x_sel;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    mac_sum;

    assign PE_READY       = (state_q != S_MAC);
    assign PE_VALID       = (state_q == S_OUT);
    assign psum_data_P2M  = psum_q;
    assign ifmap_data_P2M = ifmap_q;
    assign fltr_data_P2M  = fltr_q;

    always_comb begin
        state_d = state_q;
        ld_cnt_d = ld_cnt_q;
        k_d = k_q;
        acc_d = acc_q;
        w_d = w_q;
        x_d = x_q;
        psum_d = psum_q;
        ifmap_d = ifmap_q;
        fltr_d = fltr_q;
        w_sel = '0;
        x_sel = '0;

        for (int i = 0; i < FLTR_LEN; i++) begin
            if (k_q == KW'(i)) begin
                w_sel = w_q[i];
                x_sel = x_q[i];
            end
        end
        prod    = PW'(w_sel) * PW'(x_sel);
        mac_sum = acc_q + prod;

        xfer    = PE_EN && (state_q != S_MAC);
        compute = xfer && (ld_cnt_q >= CW'(FLTR_LEN - 1));

        case (state_q)
            S_MAC: begin
                acc_d = mac_sum;
                if (k_q == KW'(FLTR_LEN - 1)) begin
                    state_d = S_OUT;
                    psum_d  = mac_sum;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: begin
                if (compute) begin
                    state_d = S_MAC;
                    k_d     = '0;
                    acc_d   = psum_data_M2P;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase

        if (xfer) begin
            ifmap_d = ifmap_data_M2P;
            fltr_d  = fltr_data_M2P;
            for (int i = 0; i < FLTR_LEN; i++) begin
                if (ld_cnt_q == CW'(i)) begin
                    w_d[i] = fltr_data_M2P;
                end
            end
            for (int i = 0; i < FLTR_LEN - 1; i++) begin
                x_d[i] = x_q[i + 1];
            end
            x_d[FLTR_LEN-1] = ifmap_data_M2P;
            if (ld_cnt_q != CW'(FLTR_LEN)) begin
                ld_cnt_d = ld_cnt_q + CW'(1);
            end
        end

        // Clear wins over any concurrent transfer; an in-flight result is dropped.
        if (cfg_clr) begin
            state_d  = S_IDLE;
            ld_cnt_d = '0;
            k_d      = '0;
            acc_d    = acc_q;
            w_d      = w_q;
            psum_d   = psum_q;
            ifmap_d  = ifmap_q;
            fltr_d   = fltr_q;
            for (int i = 0; i < FLTR_LEN; i++) begin
                x_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ld_cnt_q <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            psum_q   <= '0;
            ifmap_q  <= '0;
            fltr_q   <= '0;
            for (int i = 0; i < FLTR_LEN; i++) begin
                w_q[i] <= '0;
                x_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            psum_q   <= psum_d;
            ifmap_q  <= ifmap_d;
            fltr_q   <= fltr_d;
            for (int i = 0; i < FLTR_LEN; i++) begin
                w_q[i] <= w_d[i];
                x_q[i] <= x_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pe_row_mac.sv
// tb/tb_pe_row_mac.sv - directed and random checks of pe_row_mac against a transaction-level model
module tb_pe_row_mac;

    localparam int DW = 16;
    localparam int L  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_clr;
    logic          PE_EN;
    logic [DW-1:0] ifmap_data_M2P;
    logic [DW-1:0] fltr_data_M2P;
    logic [2*DW-1:0] psum_data_M2P;
    logic          PE_READY;
    logic          PE_VALID;
    logic [2*DW-1:0] psum_data_P2M;
    logic [DW-1:0] ifmap_data_P2M;
    logic [DW-1:0] fltr_data_P2M;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: weights/window as plain integers, result computed at acceptance
    int        m_w [L];
    int        m_x [L];
    int        m_ld;
    int        m_busy;
    bit        m_outv;
    int        m_pend;
    int        m_psum;
    logic [DW-1:0] m_ifm;
    logic [DW-1:0] m_flt;

    pe_row_mac #(.DATA_WIDTH(DW), .FLTR_LEN(L)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_clr        (cfg_clr),
        .PE_EN          (PE_EN),
        .ifmap_data_M2P (ifmap_data_M2P),
        .fltr_data_M2P  (fltr_data_M2P),
        .psum_data_M2P  (psum_data_M2P),
        .PE_READY       (PE_READY),
        .PE_VALID       (PE_VALID),
        .psum_data_P2M  (psum_data_P2M),
        .ifmap_data_P2M (ifmap_data_P2M),
        .fltr_data_P2M  (fltr_data_P2M)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < L; i++) begin
            m_w[i] = 0;
            m_x[i] = 0;
        end
        m_ld = 0; m_busy = 0; m_outv = 0; m_pend = 0; m_psum = 0;
        m_ifm = '0; m_flt = '0;
    endtask

    task automatic model_edge();
        bit rdy;
        int s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (cfg_clr) begin
            m_ld = 0; m_busy = 0; m_outv = 0;
            for (int i = 0; i < L; i++) m_x[i] = 0;
            return;
        end
        rdy = (m_busy == 0);
        m_outv = 0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_outv = 1;
                m_psum = m_pend;
            end
        end
        if (PE_EN && rdy) begin
            m_ifm = ifmap_data_M2P;
            m_flt = fltr_data_M2P;
            if (m_ld < L) m_w[m_ld] = int'($signed(fltr_data_M2P));
            for (int i = 0; i < L - 1; i++) m_x[i] = m_x[i+1];
            m_x[L-1] = int'($signed(ifmap_data_M2P));
            if (m_ld >= L - 1) begin
                s = int'($signed(psum_data_M2P));
                for (int i = 0; i < L; i++) s += m_w[i] * m_x[i];
                m_pend = s;
                m_busy = L;
            end
            if (m_ld < L) m_ld++;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("ready", {31'b0, PE_READY}, {31'b0, m_busy == 0});
        check("valid", {31'b0, PE_VALID}, {31'b0, m_outv});
        check("psum_out", psum_data_P2M, m_psum);
        check("ifmap_fwd", {16'b0, ifmap_data_P2M}, {16'b0, m_ifm});
        check("fltr_fwd", {16'b0, fltr_data_P2M}, {16'b0, m_flt});
    endtask

    task automatic rand_in();
        PE_EN          = ($urandom_range(0, 9) < 6);
        cfg_clr        = ($urandom_range(0, 39) == 0);
        ifmap_data_M2P = 16'($urandom);
        fltr_data_M2P  = 16'($urandom);
        psum_data_M2P  = $urandom;
    endtask

    task automatic xfer(input int f, input int i, input int p, output int cyc);
        bit acc;
        cfg_clr = 0; PE_EN = 1;
        fltr_data_M2P = f[DW-1:0];
        ifmap_data_M2P = i[DW-1:0];
        psum_data_M2P = p;
        cyc = 0; acc = 0;
        while (!acc && cyc < 20) begin
            acc = (m_busy == 0);
            step();
            cyc++;
        end
        if (!acc) check("xfer_timeout", 32'd0, 32'd1);
        PE_EN = 0;
    endtask

    task automatic wait_valid(input string tag, input int expv, input int lat);
        int cyc = 0;
        while (!PE_VALID && cyc < 20) begin
            step();
            cyc++;
        end
        check(tag, psum_data_P2M, expv);
        if (lat >= 0) check({tag, "_lat"}, cyc, lat);
    endtask

    task automatic clr_pulse();
        PE_EN = 0; cfg_clr = 1;
        step();
        cfg_clr = 0;
    endtask

    initial begin
        int c;
        rst_n = 0; cfg_clr = 0; PE_EN = 0;
        ifmap_data_M2P = '0; fltr_data_M2P = '0; psum_data_M2P = '0;
        model_reset();

        // reset with random inputs
        repeat (3) begin
            rand_in();
            step();
        end
        check("rst_ready", {31'b0, PE_READY}, 32'd1);
        check("rst_valid", {31'b0, PE_VALID}, 32'd0);
        check("rst_psum", psum_data_P2M, 32'd0);
        PE_EN = 0; cfg_clr = 0; rst_n = 1;
        repeat (3) step();

        // basic MAC and back-to-back acceptance at OUT
        xfer(1, 1, 0, c);
        xfer(2, 2, 0, c);
        xfer(3, 3, 100, c);
        wait_valid("basic", 114, L);
        xfer(9, 4, 0, c);
        check("out_accept1", c, 1);
        wait_valid("slide1", 20, L);
        xfer(7, 5, -20, c);
        check("out_accept2", c, 1);
        wait_valid("slide2", 6, L);
        step();

        // signed extremes wrap
        clr_pulse();
        repeat (2) xfer(-32768, -32768, 0, c);
        xfer(-32768, -32768, 0, c);
        wait_valid("wrap", 32'hC000_0000, L);
        step();

        // negative weight on the oldest slot
        clr_pulse();
        xfer(-1, 5, 0, c);
        xfer(0, 0, 0, c);
        xfer(0, 0, 0, c);
        wait_valid("neg", -5, L);
        step();

        // PE_EN held through MAC
        clr_pulse();
        xfer(1, 1, 0, c);
        xfer(1, 2, 0, c);
        xfer(1, 3, 0, c);
        PE_EN = 1; ifmap_data_M2P = 16'd50; fltr_data_M2P = 16'd77; psum_data_M2P = '0;
        wait_valid("hold", 6, L);
        step();
        PE_EN = 0;
        wait_valid("hold_next", 55, L);
        step();

        // clear during the second MAC cycle with a concurrent offer
        clr_pulse();
        xfer(4, 4, 0, c);
        xfer(4, 4, 0, c);
        xfer(4, 4, 0, c);
        step();
        cfg_clr = 1; PE_EN = 1;
        step();
        cfg_clr = 0; PE_EN = 0;
        check("clr_idle", {31'b0, PE_READY}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("clr_novalid", {31'b0, PE_VALID}, 32'd0);
        end
        xfer(2, 1, 0, c);
        xfer(2, 1, 0, c);
        xfer(2, 1, 0, c);
        wait_valid("clr_reload", 6, L);
        step();

        // reset mid-MAC
        clr_pulse();
        xfer(3, 3, 0, c);
        xfer(3, 3, 0, c);
        xfer(3, 3, 0, c);
        step();
        rst_n = 0;
        model_reset();
        #1;
        check("rst_mac_ready", {31'b0, PE_READY}, 32'd1);
        check("rst_mac_valid", {31'b0, PE_VALID}, 32'd0);
        check("rst_mac_psum", psum_data_P2M, 32'd0);
        step();
        rst_n = 1;
        repeat (4) step();

        // random traffic
        for (int n = 0; n < 2000; n++) begin
            rand_in();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
